bsg_alu_reg: RTL and testbench

- Registered 2-bit-opcode ALU: add, subtract, bitwise AND, bitwise OR on two width_p operands.
- Result and status flags are captured in an output register with one-cycle latency, qualified by a valid bit.
- Used as a small datapath leaf; its control is typically driven by a free-running opcode counter or a sequencer.

---
 rtl/bsg_alu_reg.sv | 95 +++++++++
 tb/tb_bsg_alu_reg.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bsg_alu_reg.sv
// Registered two-operand ALU (ADD/SUB/AND/OR) with zero/carry/overflow flags.
// Every output comes straight from a flop; the result appears one cycle after v_i.
module bsg_alu_reg #(
   parameter int width_p = 4
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [1:0]         control_i,
   input  logic [width_p-1:0] a_i,
   input  logic [width_p-1:0] b_i,
   output logic               v_o,
   output logic [width_p-1:0] res_o,
   output logic               zero_o,
   output logic               carry_o,
   output logic               overflow_o
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   logic               is_sub;
   logic [width_p-1:0] b_eff;
   logic [width_p-1:0] sum;
   logic [width_p-1:0] and_v;
   logic [width_p-1:0] or_v;
   logic [width_p:0]   cy;

   // One shared adder: subtraction is a + ~b + 1, so invert b and inject a carry-in.
   assign is_sub = (control_i == OP_SUB);
   assign cy[0]  = is_sub;

   for (genvar gi = 0; gi < width_p; gi++) begin : g_bit
      assign b_eff[gi]  = b_i[gi] ^ is_sub;
      assign sum[gi]    = a_i[gi] ^ b_eff[gi] ^ cy[gi];
      assign cy[gi+1]   = (a_i[gi] & b_eff[gi]) | (cy[gi] & (a_i[gi] ^ b_eff[gi]));
      assign and_v[gi]  = a_i[gi] & b_i[gi];
      assign or_v[gi]   = a_i[gi] | b_i[gi];
   end

   logic               v_q;
   logic [width_p-1:0] res_q,  res_d;
   logic               zero_q, zero_d;
   logic               carry_q, carry_d;
   logic               ovf_q,  ovf_d;

   always_comb begin
      res_d   = sum;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      case (control_i)
         OP_ADD: begin
            res_d   = sum;
            carry_d = cy[width_p];
            ovf_d   = cy[width_p] ^ cy[width_p-1];
         end
         OP_SUB: begin
            // A missing carry-out of a + ~b + 1 means a < b unsigned.
            res_d   = sum;
            carry_d = ~cy[width_p];
            ovf_d   = cy[width_p] ^ cy[width_p-1];
         end
         OP_AND: res_d = and_v;
         OP_OR:  res_d = or_v;
      endcase
      zero_d = ~|res_d;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         v_q     <= 1'b0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         v_q <= v_i;
         if (v_i) begin
            res_q   <= res_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
         end
      end
   end

   assign v_o        = v_q;
   assign res_o      = res_q;
   assign zero_o     = zero_q;
   assign carry_o    = carry_q;
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_bsg_alu_reg.sv
// Bench for bsg_alu_reg: integer-arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed literal results.
module tb_bsg_alu_reg;

   localparam int W = 4;
   localparam int M = 1 << W;
   localparam int H = 1 << (W - 1);

   typedef struct packed {
      logic         v;
      logic [W-1:0] res;
      logic         z;
      logic         c;
      logic         o;
   } exp_t;

   logic         clk_i = 1'b0;
   logic         reset_i = 1'b1;
   logic         v_i = 1'b0;
   logic [1:0]   control_i = 2'b00;
   logic [W-1:0] a_i = '0;
   logic [W-1:0] b_i = '0;
   logic         v_o;
   logic [W-1:0] res_o;
   logic         zero_o;
   logic         carry_o;
   logic         overflow_o;

   int checks = 0;
   int failures = 0;

   bsg_alu_reg #(.width_p(W)) dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .v_i        (v_i),
      .control_i  (control_i),
      .a_i        (a_i),
      .b_i        (b_i),
      .v_o        (v_o),
      .res_o      (res_o),
      .zero_o     (zero_o),
      .carry_o    (carry_o),
      .overflow_o (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference: plain integer arithmetic, signed overflow judged by range.
   function automatic exp_t compute(input logic [1:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int ai, bi, sa, sb, full, st;
      ai = int'(a);
      bi = int'(b);
      sa = (ai >= H) ? ai - M : ai;
      sb = (bi >= H) ? bi - M : bi;
      e = '0;
      e.v = 1'b1;
      case (ctl)
         2'b00: begin
            full  = ai + bi;
            st    = sa + sb;
            e.res = W'(full);
            e.c   = (full >= M);
            e.o   = (st > H - 1) || (st < -H);
         end
         2'b01: begin
            full  = ai - bi;
            st    = sa - sb;
            e.res = W'(full);
            e.c   = (ai < bi);
            e.o   = (st > H - 1) || (st < -H);
         end
         2'b10: e.res = a & b;
         default: e.res = a | b;
      endcase
      e.z = (e.res == '0);
      return e;
   endfunction

   exp_t model_q = '0;

   always @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         model_q <= '0;
      end else if (v_i) begin
         model_q <= compute(control_i, a_i, b_i);
      end else begin
         model_q.v <= 1'b0;
      end
   end

   always @(negedge clk_i) begin
      checks++;
      if ({v_o, res_o, zero_o, carry_o, overflow_o} !== model_q) begin
         failures++;
         $display("FAIL model_cmp t=%0t got v=%b res=%b z=%b c=%b o=%b want v=%b res=%b z=%b c=%b o=%b",
                  $time, v_o, res_o, zero_o, carry_o, overflow_o,
                  model_q.v, model_q.res, model_q.z, model_q.c, model_q.o);
      end
   end

   task automatic check_lit(input string name, input logic v, input logic [W-1:0] res,
                            input logic z, input logic c, input logic o);
      checks++;
      if ({v_o, res_o, zero_o, carry_o, overflow_o} !== {v, res, z, c, o}) begin
         failures++;
         $display("FAIL %s got v=%b res=%b z=%b c=%b o=%b want v=%b res=%b z=%b c=%b o=%b",
                  name, v_o, res_o, zero_o, carry_o, overflow_o, v, res, z, c, o);
      end else begin
         $display("ok %s v=%b res=%b z=%b c=%b o=%b", name, v_o, res_o, zero_o, carry_o, overflow_o);
      end
   endtask

   // Drive one cycle's inputs, let the edge capture them, land 2 time units past it.
   task automatic step(input logic v, input logic [1:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b);
      v_i = v;
      control_i = ctl;
      a_i = a;
      b_i = b;
      @(posedge clk_i);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      check_lit("reset_state", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      @(posedge clk_i);
      @(posedge clk_i);
      #2;
      reset_i = 1'b0;

      // Opcode sweep on consecutive cycles.
      step(1'b1, 2'b00, 4'b0001, 4'b0011); check_lit("sweep_add", 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2'b01, 4'b0001, 4'b0011); check_lit("sweep_sub", 1'b1, 4'b1110, 1'b0, 1'b1, 1'b0);
      step(1'b1, 2'b10, 4'b0001, 4'b0011); check_lit("sweep_and", 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2'b11, 4'b0001, 4'b0011); check_lit("sweep_or",  1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);

      step(1'b1, 2'b00, 4'b1111, 4'b0001); check_lit("wrap_zero", 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
      step(1'b1, 2'b00, 4'b0111, 4'b0001); check_lit("ovf_add",   1'b1, 4'b1000, 1'b0, 1'b0, 1'b1);
      step(1'b1, 2'b01, 4'b1000, 4'b0001); check_lit("ovf_sub",   1'b1, 4'b0111, 1'b0, 1'b0, 1'b1);
      step(1'b1, 2'b01, 4'b0101, 4'b0101); check_lit("sub_equal", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
      step(1'b1, 2'b10, 4'b1010, 4'b0101); check_lit("and_zero",  1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);

      // Valid gating: flags and result hold while v_i is low.
      step(1'b1, 2'b00, 4'b0011, 4'b0100); check_lit("gate_accept", 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0);
      step(1'b0, 2'b11, 4'b1111, 4'b1111); check_lit("gate_hold1",  1'b0, 4'b0111, 1'b0, 1'b0, 1'b0);
      step(1'b0, 2'b01, 4'b0000, 4'b1000); check_lit("gate_hold2",  1'b0, 4'b0111, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset between edges while v_o is high.
      step(1'b1, 2'b00, 4'b1001, 4'b1001); check_lit("pre_reset", 1'b1, 4'b0010, 1'b0, 1'b1, 1'b1);
      #1 reset_i = 1'b1;
      #1 check_lit("async_reset", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      @(posedge clk_i);
      #2 check_lit("reset_hold", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      reset_i = 1'b0;
      step(1'b1, 2'b01, 4'b0010, 4'b0010); check_lit("post_reset_sub", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);

      // Full operand/opcode sweep at one op per cycle, checked by the model each cycle.
      for (int op = 0; op < 4; op++) begin
         for (int a = 0; a < M; a++) begin
            for (int b = 0; b < M; b++) begin
               step(((a + b) % 5) != 0, 2'(op), W'(a), W'(b));
            end
         end
      end
      step(1'b0, 2'b00, 4'b0000, 4'b0000);
      @(negedge clk_i);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
